// File: rtl/fft4_twiddle_mul.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : fft4_twiddle_mul
// Description : Twiddle-multiply stage for a 4-point FFT datapath. Generates
//               the twiddle table address, aligns the table output with the
//               sample, then does a pipelined complex multiply followed by
//               round-half-up and saturation back to WIDTH bits.
// Revision    : 1.0 - initial release
// ============================================================================
module fft4_twiddle_mul #(
  parameter int WIDTH  = 18,
  parameter int FRAC   = 10,
  parameter int TW_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    di_en,
  input  logic                    di_sof,
  input  logic signed [WIDTH-1:0] di_re,
  input  logic signed [WIDTH-1:0] di_im,
  output logic [1:0]              tw_addr,
  input  logic signed [WIDTH-1:0] tw_re,
  input  logic signed [WIDTH-1:0] tw_im,
  output logic                    do_en,
  output logic signed [WIDTH-1:0] do_re,
  output logic signed [WIDTH-1:0] do_im,
  output logic                    ovf,
  input  logic                    ovf_clr
);

  localparam int PW = 2 * WIDTH;      // product width
  localparam int SW = 2 * WIDTH + 1;  // sum width

  localparam logic signed [SW-1:0] RND  = SW'(2 ** (FRAC - 1));
  localparam logic signed [SW-1:0] MAXV = SW'((2 ** (WIDTH - 1)) - 1);
  localparam logic signed [SW-1:0] MINV = -MAXV - SW'(1);

  // --------------------------------------------------------------------------
  // Twiddle index counter
  // --------------------------------------------------------------------------
  logic [1:0] cnt_q, cnt_d;

  // Next index: a start-of-frame sample takes index 0, so the follower is 1.
  always_comb begin
    cnt_d = cnt_q;
    if (di_en) begin
      cnt_d = di_sof ? 2'd1 : cnt_q + 2'd1;
    end
  end

  // Index counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 2'd0;
    else        cnt_q <= cnt_d;
  end

  assign tw_addr = di_sof ? 2'd0 : cnt_q;

  // --------------------------------------------------------------------------
  // Stage A: delay the sample to meet the table output
  // --------------------------------------------------------------------------
  logic                    al_en;
  logic signed [WIDTH-1:0] al_re;
  logic signed [WIDTH-1:0] al_im;

  generate
    if (TW_LAT == 1) begin : g_lat1
      logic                    a_en_q;
      logic signed [WIDTH-1:0] a_re_q;
      logic signed [WIDTH-1:0] a_im_q;

      // One-cycle alignment register matching the table's output register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_en_q <= 1'b0;
          a_re_q <= '0;
          a_im_q <= '0;
        end else begin
          a_en_q <= di_en;
          a_re_q <= di_re;
          a_im_q <= di_im;
        end
      end

      assign al_en = a_en_q;
      assign al_re = a_re_q;
      assign al_im = a_im_q;
    end else begin : g_lat0
      assign al_en = di_en;
      assign al_re = di_re;
      assign al_im = di_im;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Stage M: four partial products
  // --------------------------------------------------------------------------
  logic signed [PW-1:0] a_x, b_x, c_x, d_x;
  assign a_x = $signed({{WIDTH{al_re[WIDTH-1]}}, al_re});
  assign b_x = $signed({{WIDTH{al_im[WIDTH-1]}}, al_im});
  assign c_x = $signed({{WIDTH{tw_re[WIDTH-1]}}, tw_re});
  assign d_x = $signed({{WIDTH{tw_im[WIDTH-1]}}, tw_im});

  logic                 m_en_q;
  logic signed [PW-1:0] ac_q, bd_q, ad_q, bc_q;

  // Register the products; the full 2*WIDTH result is exact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_en_q <= 1'b0;
      ac_q   <= '0;
      bd_q   <= '0;
      ad_q   <= '0;
      bc_q   <= '0;
    end else begin
      m_en_q <= al_en;
      ac_q   <= a_x * c_x;
      bd_q   <= b_x * d_x;
      ad_q   <= a_x * d_x;
      bc_q   <= b_x * c_x;
    end
  end

  // --------------------------------------------------------------------------
  // Stage S: real and imaginary sums, one guard bit
  // --------------------------------------------------------------------------
  logic                 s_en_q;
  logic signed [SW-1:0] re_sum_q, im_sum_q;

  // Register re = ac - bd and im = ad + bc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_en_q   <= 1'b0;
      re_sum_q <= '0;
      im_sum_q <= '0;
    end else begin
      s_en_q   <= m_en_q;
      re_sum_q <= $signed({ac_q[PW-1], ac_q}) - $signed({bd_q[PW-1], bd_q});
      im_sum_q <= $signed({ad_q[PW-1], ad_q}) + $signed({bc_q[PW-1], bc_q});
    end
  end

  // --------------------------------------------------------------------------
  // Stage R: round half up, saturate, register outputs
  // --------------------------------------------------------------------------
  // Returns {saturated, value}.
  function automatic logic [WIDTH:0] round_sat(input logic signed [SW-1:0] s);
    logic signed [SW-1:0] t;
    t = (s + RND) >>> FRAC;
    if (t > MAXV)      round_sat = {1'b1, MAXV[WIDTH-1:0]};
    else if (t < MINV) round_sat = {1'b1, MINV[WIDTH-1:0]};
    else               round_sat = {1'b0, t[WIDTH-1:0]};
  endfunction

  logic [WIDTH:0] r_re, r_im;
  assign r_re = round_sat(re_sum_q);
  assign r_im = round_sat(im_sum_q);

  logic                    do_en_q;
  logic signed [WIDTH-1:0] do_re_q, do_im_q;
  logic                    ovf_q;

  // Output register; data holds while no valid sample arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      do_en_q <= 1'b0;
      do_re_q <= '0;
      do_im_q <= '0;
    end else begin
      do_en_q <= s_en_q;
      if (s_en_q) begin
        do_re_q <= r_re[WIDTH-1:0];
        do_im_q <= r_im[WIDTH-1:0];
      end
    end
  end

  // Sticky overflow; a new saturation wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               ovf_q <= 1'b0;
    else if (s_en_q && (r_re[WIDTH] || r_im[WIDTH])) ovf_q <= 1'b1;
    else if (ovf_clr)                         ovf_q <= 1'b0;
  end

  assign do_en = do_en_q;
  assign do_re = do_re_q;
  assign do_im = do_im_q;
  assign ovf   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_fft4_twiddle_mul.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_fft4_twiddle_mul
// Description : Directed self-checking bench for fft4_twiddle_mul with a
//               registered 4-entry twiddle table model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft4_twiddle_mul;

  localparam int WIDTH = 18;
  localparam int LAT   = 4;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    di_en, di_sof;
  logic signed [WIDTH-1:0] di_re, di_im;
  logic [1:0]              tw_addr;
  logic signed [WIDTH-1:0] tw_re, tw_im;
  logic                    do_en;
  logic signed [WIDTH-1:0] do_re, do_im;
  logic                    ovf;
  logic                    ovf_clr;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  longint q_re[$];
  longint q_im[$];
  int     q_t[$];

  logic signed [WIDTH-1:0] tab_re [4];
  logic signed [WIDTH-1:0] tab_im [4];

  fft4_twiddle_mul #(.WIDTH(WIDTH), .FRAC(10), .TW_LAT(1)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .di_en   (di_en),
    .di_sof  (di_sof),
    .di_re   (di_re),
    .di_im   (di_im),
    .tw_addr (tw_addr),
    .tw_re   (tw_re),
    .tw_im   (tw_im),
    .do_en   (do_en),
    .do_re   (do_re),
    .do_im   (do_im),
    .ovf     (ovf),
    .ovf_clr (ovf_clr)
  );

  always #5 clk = ~clk;

  // Cycle counter used for latency checks.
  always @(posedge clk) cyc <= cyc + 1;

  // Twiddle table model with one cycle of read latency.
  always @(posedge clk) begin
    tw_re <= tab_re[tw_addr];
    tw_im <= tab_im[tw_addr];
  end

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Output monitor: every do_en must match the oldest expectation.
  always @(posedge clk) begin
    #3;
    if (do_en) begin
      if (q_re.size() == 0) begin
        check("spurious_do_en", 1, 0);
      end else begin
        check("do_re", longint'(do_re), q_re.pop_front());
        check("do_im", longint'(do_im), q_im.pop_front());
        check("latency", longint'(cyc - q_t.pop_front()), LAT);
      end
    end
  end

  task automatic send(input logic sof, input longint re, input longint im,
                      input logic [1:0] exp_addr, input longint exp_re,
                      input longint exp_im);
    @(posedge clk);
    #1;
    di_en  = 1'b1;
    di_sof = sof;
    di_re  = WIDTH'(re);
    di_im  = WIDTH'(im);
    q_re.push_back(exp_re);
    q_im.push_back(exp_im);
    q_t.push_back(cyc);
    #1;
    check("tw_addr", longint'(tw_addr), longint'(exp_addr));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      di_en  = 1'b0;
      di_sof = 1'b0;
      di_re  = WIDTH'($urandom);
      di_im  = WIDTH'($urandom);
    end
  endtask

  task automatic flush();
    q_re.delete();
    q_im.delete();
    q_t.delete();
  endtask

  initial begin
    tab_re[0] = 18'sd1024;  tab_im[0] = 18'sd0;
    tab_re[1] = 18'sd0;     tab_im[1] = -18'sd1024;
    tab_re[2] = -18'sd1024; tab_im[2] = -18'sd1;
    tab_re[3] = -18'sd1;    tab_im[3] = 18'sd1024;

    rst_n   = 1'b0;
    di_en   = 1'b0;
    di_sof  = 1'b0;
    di_re   = '0;
    di_im   = '0;
    ovf_clr = 1'b0;

    // 1: reset with random traffic, then idle
    repeat (5) begin
      @(posedge clk);
      #1;
      di_en  = 1'($urandom);
      di_sof = 1'b0;
      di_re  = WIDTH'($urandom);
      di_im  = WIDTH'($urandom);
      #1;
      check("rst_tw_addr", longint'(tw_addr), 0);
    end
    check("rst_do_en", longint'(do_en), 0);
    check("rst_do_re", longint'(do_re), 0);
    check("rst_do_im", longint'(do_im), 0);
    check("rst_ovf", longint'(ovf), 0);
    di_en = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(10);
    check("idle_do_en", longint'(do_en), 0);

    // 2: back-to-back frame
    send(1'b1, 100, 50, 2'd0, 100, 50);
    send(1'b0, 100, 50, 2'd1, 50, -100);
    send(1'b0, 100, 50, 2'd2, -100, -50);
    send(1'b0, 100, 50, 2'd3, -50, 100);
    idle(6);

    // 3: same frame with one idle cycle between samples
    send(1'b1, 100, 50, 2'd0, 100, 50);
    idle(1);
    send(1'b0, 100, 50, 2'd1, 50, -100);
    idle(1);
    send(1'b0, 100, 50, 2'd2, -100, -50);
    idle(1);
    send(1'b0, 100, 50, 2'd3, -50, 100);
    idle(6);

    // 4: start-of-frame on the third sample restarts the index
    send(1'b1, 100, 50, 2'd0, 100, 50);
    send(1'b0, 100, 50, 2'd1, 50, -100);
    send(1'b1, 100, 50, 2'd0, 100, 50);
    send(1'b0, 100, 50, 2'd1, 50, -100);
    idle(6);
    check("ovf_pre", longint'(ovf), 0);

    // 5: saturation sets ovf, ovf_clr clears it
    send(1'b1, 100, 50, 2'd0, 100, 50);
    send(1'b0, 100, 50, 2'd1, 50, -100);
    send(1'b0, -131072, 0, 2'd2, 131071, 128);
    idle(6);
    check("ovf_set", longint'(ovf), 1);
    @(posedge clk);
    #1;
    ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    ovf_clr = 1'b0;
    #1;
    check("ovf_clr", longint'(ovf), 0);

    // 6: reset with samples in flight, then a fresh frame without sof
    send(1'b1, 100, 50, 2'd0, 100, 50);
    send(1'b0, 100, 50, 2'd1, 50, -100);
    send(1'b0, 100, 50, 2'd2, -100, -50);
    rst_n = 1'b0;
    di_en = 1'b0;
    flush();
    #1;
    check("midrst_do_en", longint'(do_en), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(8);
    check("postrst_do_en", longint'(do_en), 0);
    send(1'b0, 200, -300, 2'd0, 200, -300);
    send(1'b0, 200, -300, 2'd1, -300, -200);
    idle(1);

    // drain outstanding expectations with a bounded wait
    for (int i = 0; i < 20 && q_re.size() != 0; i++) @(posedge clk);
    #4;
    check("drain", longint'(q_re.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
